// File: rtl/mem_fetch_ctrl.sv
// Sequences 16x8 RAM reads (setup/access/hold) and captures fetched instructions or data bytes.
// Latency: 3 cycles from request edge to capture; done pulses the cycle after capture.
// Backpressure: none queued; requests arriving while busy are dropped, caller must watch busy/done.
module mem_fetch_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic [3:0] data_addr,
    input  logic       pc_load,
    input  logic [3:0] pc_din,
    output logic [3:0] mem_address,
    output logic       mem_ce,
    input  logic [7:0] mem_data,
    output logic [3:0] pc,
    output logic [3:0] ir_opcode,
    output logic [3:0] ir_operand,
    output logic [7:0] data_q,
    output logic       busy,
    output logic       done,
    output logic       halted
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t     state;
    logic [7:0] ir;
    logic       is_data;

    assign ir_opcode  = ir[7:4];
    assign ir_operand = ir[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= 4'd0;
            ir          <= 8'd0;
            data_q      <= 8'd0;
            mem_address <= 4'd0;
            mem_ce      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            is_data     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // One action per edge: jump beats fetch beats data read.
                    if (pc_load) begin
                        pc <= pc_din;
                    end else if (fetch_req && !halted) begin
                        mem_address <= pc;
                        is_data     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end else if (data_req) begin
                        mem_address <= data_addr;
                        is_data     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    mem_ce <= 1'b1;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // mem_ce is still high here, so the bus is driven when sampled.
                    mem_ce <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                    if (is_data) begin
                        data_q <= mem_data;
                    end else begin
                        ir <= mem_data;
                        pc <= pc + 4'd1;
                        if (mem_data[7:4] == 4'hF)
                            halted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fetch_ctrl.sv
module tb_mem_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req, data_req, pc_load;
    logic [3:0] data_addr, pc_din;
    logic [3:0] mem_address;
    logic       mem_ce;
    logic [7:0] mem_data;
    logic [3:0] pc, ir_opcode, ir_operand;
    logic [7:0] data_q;
    logic       busy, done, halted;

    always #5 clk = ~clk;

    mem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .data_req(data_req), .data_addr(data_addr),
        .pc_load(pc_load), .pc_din(pc_din),
        .mem_address(mem_address), .mem_ce(mem_ce), .mem_data(mem_data),
        .pc(pc), .ir_opcode(ir_opcode), .ir_operand(ir_operand),
        .data_q(data_q), .busy(busy), .done(done), .halted(halted)
    );

    logic [7:0] ram [16];
    assign mem_data = mem_ce ? ram[mem_address] : 8'hzz;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       f, d;
        logic [3:0] a;
        logic       l;
        logic [3:0] din;
        logic       acc;
        logic [3:0] eaddr;
        logic [3:0] epc;
        logic [7:0] eir;
        logic [7:0] edq;
        logic       eh;
    } vec_t;

    vec_t v[14];

    // Waits for done after an accepted request (called at the first negedge after
    // the accept edge); checks ce width, address stability and latency.
    task automatic wait_access(input string tag, input logic [3:0] eaddr);
        int  ce_cnt = 0;
        int  lat    = -1;
        for (int k = 0; k < 8; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (mem_ce) begin
                ce_cnt++;
                check({tag, "_addr"}, mem_address, eaddr);
            end
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_ce_cycles"}, ce_cnt, 2);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        foreach (ram[i]) ram[i] = 8'h00;
        ram[0] = 8'h0A; ram[1] = 8'h29; ram[2] = 8'h1B; ram[3] = 8'h1C;
        ram[4] = 8'hE0; ram[5] = 8'hF0; ram[12] = 8'h01; ram[15] = 8'h1A;

        //        f     d     a     l     din   acc   eaddr epc   eir    edq    eh
        v[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd1, 8'h0A, 8'h00, 1'b0};
        v[1]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'hF, 1'b0, 4'd0, 4'hF, 8'h0A, 8'h00, 1'b0};
        v[2]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'hF, 4'd0, 8'h1A, 8'h00, 1'b0};
        v[3]  = '{1'b0, 1'b1, 4'hC, 1'b0, 4'd0, 1'b1, 4'hC, 4'd0, 8'h1A, 8'h01, 1'b0};
        v[4]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 4'd0, 4'd1, 8'h0A, 8'h01, 1'b0};
        v[5]  = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd2, 8'h0A, 8'h01, 1'b0};
        v[6]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd1, 8'h0A, 8'h01, 1'b0};
        v[7]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 4'd2, 8'h29, 8'h01, 1'b0};
        v[8]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd3, 8'h1B, 8'h01, 1'b0};
        v[9]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd4, 8'h1C, 8'h01, 1'b0};
        v[10] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd5, 8'hE0, 8'h01, 1'b0};
        v[11] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd6, 8'hF0, 8'h01, 1'b1};
        v[12] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 8'hF0, 8'h01, 1'b1};
        v[13] = '{1'b0, 1'b1, 4'hF, 1'b0, 4'd0, 1'b1, 4'hF, 4'd6, 8'hF0, 8'h1A, 1'b1};

        rst_n = 1'b0; fetch_req = 0; data_req = 0; pc_load = 0; data_addr = 0; pc_din = 0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 4'd0);
        check("rst_ir", {ir_opcode, ir_operand}, 8'h00);
        check("rst_data_q", data_q, 8'h00);
        check("rst_addr", mem_address, 4'd0);
        check("rst_ce", mem_ce, 1'b0);
        check("rst_busy_done_halted", {busy, done, halted}, 3'b000);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            fetch_req = v[i].f; data_req = v[i].d; data_addr = v[i].a;
            pc_load = v[i].l; pc_din = v[i].din;
            @(negedge clk);
            fetch_req = 0; data_req = 0; pc_load = 0;
            if (v[i].acc) begin
                check({tag, "_busy_start"}, busy, 1'b1);
                wait_access(tag, v[i].eaddr);
            end else begin
                int act = 0;
                for (int k = 0; k < 4; k++) begin
                    if (mem_ce || busy || done) act++;
                    @(negedge clk);
                end
                check({tag, "_no_activity"}, act, 0);
            end
            check({tag, "_pc"}, pc, v[i].epc);
            check({tag, "_ir"}, {ir_opcode, ir_operand}, v[i].eir);
            check({tag, "_data_q"}, data_q, v[i].edq);
            check({tag, "_halted"}, halted, v[i].eh);
        end

        // Requests during busy are dropped; back-to-back accept at the done cycle.
        @(negedge clk);
        data_req = 1; data_addr = 4'd0;
        @(negedge clk);
        check("drop_busy_start", busy, 1'b1);
        pc_load = 1; pc_din = 4'd9; fetch_req = 1; data_addr = 4'hC;
        @(negedge clk);
        @(negedge clk);
        pc_load = 0; fetch_req = 0; data_req = 0;
        @(negedge clk);
        check("drop_done", done, 1'b1);
        check("drop_data_q", data_q, 8'h0A);
        check("drop_pc", pc, 4'd6);
        data_req = 1; data_addr = 4'hC;
        @(negedge clk);
        data_req = 0;
        check("b2b_busy", busy, 1'b1);
        wait_access("b2b", 4'hC);
        check("b2b_data_q", data_q, 8'h01);
        check("b2b_pc", pc, 4'd6);

        // Reset during ACCESS: ce drops at once, no capture, no done.
        @(negedge clk);
        data_req = 1; data_addr = 4'hF;
        @(negedge clk);
        data_req = 0;
        @(negedge clk);
        check("mid_ce_access", mem_ce, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_ce_drop", mem_ce, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_pc", pc, 4'd0);
        check("mid_ir", {ir_opcode, ir_operand}, 8'h00);
        check("mid_data_q", data_q, 8'h00);
        check("mid_halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int act = 0;
            for (int k = 0; k < 4; k++) begin
                if (done || mem_ce) act++;
                @(negedge clk);
            end
            check("mid_no_done", act, 0);
        end

        // Halt cleared by reset: fetch works again.
        fetch_req = 1;
        @(negedge clk);
        fetch_req = 0;
        wait_access("post_rst", 4'd0);
        check("post_rst_ir", {ir_opcode, ir_operand}, 8'h0A);
        check("post_rst_pc", pc, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_fetch_ctrl.md
# mem_fetch_ctrl

Sequencing master for the 16x8 program/data RAM. Owns the program counter, drives the RAM's `address`/`ce` pins with a setup/access/hold sequence, and captures the returned byte into the instruction register (opcode/operand split) or the data register. Sits between the control unit, which issues single-cycle fetch/data requests, and the RAM, whose output floats to Z whenever `ce` is low.

## Interface
- No parameters. Address width 4 and data width 8 are fixed.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_req` in 1: one-cycle request to fetch the instruction at `pc`.
- `data_req` in 1: one-cycle request to read the byte at `data_addr`.
- `data_addr` in 4: operand address; sampled when `data_req` is accepted.
- `pc_load` in 1: jump request; loads `pc_din` into `pc`.
- `pc_din` in 4: jump target.
- `mem_address` out 4: RAM address; registered.
- `mem_ce` out 1: RAM chip enable; registered.
- `mem_data` in 8: RAM data output.
- `pc` out 4: program counter.
- `ir_opcode` out 4: `ir[7:4]` of the last fetched instruction.
- `ir_operand` out 4: `ir[3:0]` of the last fetched instruction.
- `data_q` out 8: last byte read by a data request.
- `busy` out 1: high in SETUP, ACCESS and HOLD.
- `done` out 1: one-cycle pulse after each capture.
- `halted` out 1: set when a fetched opcode is 4'hF.

## Operation
- Reset values: `pc`=0, `ir`=0, `data_q`=0, `mem_address`=0, `mem_ce`=0, `busy`=0, `done`=0, `halted`=0, state IDLE.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE, acceptance priority each edge (only one action per edge; rejected inputs are dropped, not queued):
  1. `pc_load`: `pc` <= `pc_din`.
  2. `fetch_req` with `halted`=0: `mem_address` <= `pc`, kind=FETCH, go to SETUP.
  3. `data_req`: `mem_address` <= `data_addr`, kind=DATA, go to SETUP.
- `data_req` is honoured even when `halted`=1.
- SETUP: `mem_ce`=0 with address stable. Next state ACCESS.
- ACCESS: `mem_ce`=1. Next state HOLD.
- HOLD: `mem_ce`=1. On the exiting edge, `mem_data` is sampled, `mem_ce` <= 0, and the state returns to IDLE.
  - FETCH capture: `ir` <= `mem_data`; `pc` <= `pc`+1 modulo 16 (15 wraps to 0). If `mem_data[7:4]`==4'hF, `halted` <= 1.
  - DATA capture: `data_q` <= `mem_data`; `pc` is unchanged.
- `done` is registered. It is high for exactly the one cycle after the HOLD exit.
- `mem_data` is only ever sampled while `mem_ce`=1, so Z values from the floating bus are never captured.
- All of `fetch_req`, `data_req` and `pc_load` are ignored while `busy`=1.
- `halted` clears only on reset.

## Timing
- Request seen at edge E0:
  - SETUP during cycle E0–E1.
  - ACCESS (`mem_ce`=1) during E1–E2.
  - HOLD during E2–E3.
  - Capture at E3.
  - `done`=1 and new `ir`/`data_q`/`pc` visible during E3–E4.
- Latency is 3 cycles from request edge to result. `busy` is high for exactly 3 cycles per access.
- Back-to-back: a new request may be accepted at E3+1, the edge at which `done` is high. Sustained throughput is one access per 4 cycles.
- `mem_address` never changes while `mem_ce`=1.
- `mem_ce` is high for exactly 2 consecutive cycles per access.
- Reset mid-operation: all outputs go to their reset values asynchronously. `mem_ce` drops immediately, no capture occurs, and no `done` pulse is produced.

## Test plan
- Reset, RAM[0]=8'h0A, `fetch_req` pulse -> `mem_ce` high for exactly 2 cycles with `mem_address`=0, then `done` pulse with `ir_opcode`=0, `ir_operand`=A, `pc`=1.
- `pc_load` with `pc_din`=15, then fetch of RAM[15]=8'h1A -> `ir`=8'h1A, `pc` wraps to 0.
- `data_req` with `data_addr`=12 and RAM[12]=8'h01 -> `data_q`=8'h01, `pc` unchanged, `ir` unchanged.
- `fetch_req` and `data_req` asserted in the same IDLE cycle -> only FETCH is performed; `data_q` is unchanged. Requests asserted during `busy` are dropped.
- Program 0A,29,1B,1C,E0,F0 fetched sequentially -> `halted` set after the 6th fetch with `pc`=6. A further `fetch_req` produces no `mem_ce` activity, while `data_req` still completes.
- `rst_n` low during ACCESS -> `mem_ce`=0 immediately, no `done` pulse, `pc`=0, `ir`=0.
